// File: rtl/vpi_var_pattern_driver.sv
// -----------------------------------------------------------------------------
// vpi_var_pattern_driver
//
// Writer end of a public-variable test path. After a start pulse it presents
// NUM_VECS vectors, one at a time, on a set of variables of different shapes
// (one-bit, packed, signed packed, little-endian packed, multi-dimensional
// packed, packed-over-unpacked). A host reads each vector and acknowledges it.
//
// Handshake (4-phase valid/ack):
//   valid rises with a freshly loaded vector; seq and data are stable while
//   valid=1. The host raises host_ack once it has read the vector; valid falls
//   on the edge that samples host_ack=1. The host then drops host_ack; the edge
//   that samples host_ack=0 either loads the next vector with valid=1 or, after
//   the last vector, raises done. Data outputs hold between vectors and keep
//   the last vector after done. Every waiting phase is bounded by
//   TIMEOUT_CYCLES; on expiry the block stops with timeout_err=1.
//
// Ports:
//   clk          sole clock, posedge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, accepted only in IDLE
//   host_ack     host acknowledge
//   valid        presented vector is stable and readable
//   seq[7:0]     index k of the presented vector
//   done         sticky, all vectors acknowledged
//   timeout_err  sticky, a handshake phase timed out
//   onebit       k[0]
//   a_p1[1:0]    k[1:0]
//   a_sp1[1:0]   signed, ~k[1:0]
//   a_p1le[0:1]  element 0 = k[0], element 1 = k[1]
//   a_p21        [2]=k[1:0], [1]=~k[1:0], [0]=k[2:1]
//   a_p1u1[3:0]  flattened [1:0] of [1:0]: [3:2]=k[3:2], [1:0]=k[1:0]
//   state_dbg    current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module vpi_var_pattern_driver #(
    parameter int NUM_VECS       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              host_ack,
    output logic              valid,
    output logic [7:0]        seq,
    output logic              done,
    output logic              timeout_err,
    output logic              onebit,
    output logic [1:0]        a_p1,
    output logic signed [1:0] a_sp1,
    output logic [0:1]        a_p1le,
    output logic [2:0][1:0]   a_p21,
    output logic [3:0]        a_p1u1,
    output logic [2:0]        state_dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_K   = 8'(NUM_VECS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESENT = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    typedef struct packed {
        logic            onebit;
        logic [1:0]      p1;
        logic [1:0]      sp1;
        logic [0:1]      p1le;
        logic [2:0][1:0] p21;
        logic [3:0]      p1u1;
    } vec_t;

    // Every field is a function of k[3:0] only; higher index bits never
    // reach an output.
    function automatic vec_t map_vec(input logic [3:0] k);
        vec_t v;
        v.onebit  = k[0];
        v.p1      = k[1:0];
        v.sp1     = ~k[1:0];
        v.p1le[0] = k[0];
        v.p1le[1] = k[1];
        v.p21[2]  = k[1:0];
        v.p21[1]  = ~k[1:0];
        v.p21[0]  = k[2:1];
        v.p1u1    = {k[3:2], k[1:0]};
        return v;
    endfunction

    state_e        state_q, state_d;
    logic [7:0]    k_q, k_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    vec_t          vec_q, vec_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        valid_d = valid_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRESENT;
                    k_d     = 8'd0;
                    vec_d   = map_vec(4'd0);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_PRESENT: begin
                if (host_ack) begin
                    state_d = ST_RELEASE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!host_ack) begin
                    cnt_d = '0;
                    if (k_q == LAST_K) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        // Next vector loads on the same edge that sees ack low.
                        state_d = ST_PRESENT;
                        k_d     = k_q + 8'd1;
                        vec_d   = map_vec(k_d[3:0]);
                        valid_d = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                valid_d = 1'b0;
            end

            ST_ERROR: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

    assign valid       = valid_q;
    assign seq         = k_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign onebit      = vec_q.onebit;
    assign a_p1        = vec_q.p1;
    assign a_sp1       = vec_q.sp1;
    assign a_p1le      = vec_q.p1le;
    assign a_p21       = vec_q.p21;
    assign a_p1u1      = vec_q.p1u1;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_vpi_var_pattern_driver.sv
`timescale 1ns/1ps
module tb_vpi_var_pattern_driver;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0, host_ack = 1'b0;
    logic start1 = 1'b0, ack1 = 1'b0;

    // main instance (NUM_VECS = 8)
    logic              valid, done, timeout_err, onebit;
    logic [7:0]        seq;
    logic [1:0]        a_p1;
    logic signed [1:0] a_sp1;
    logic [0:1]        a_p1le;
    logic [2:0][1:0]   a_p21;
    logic [3:0]        a_p1u1;
    logic [2:0]        state_dbg;

    // single-vector instance
    logic              valid1, done1, timeout_err1, onebit1;
    logic [7:0]        seq1;
    logic [1:0]        a_p1_1;
    logic signed [1:0] a_sp1_1;
    logic [0:1]        a_p1le_1;
    logic [2:0][1:0]   a_p21_1;
    logic [3:0]        a_p1u1_1;
    logic [2:0]        state_dbg1;

    vpi_var_pattern_driver #(.NUM_VECS(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .host_ack(host_ack),
        .valid(valid), .seq(seq), .done(done), .timeout_err(timeout_err),
        .onebit(onebit), .a_p1(a_p1), .a_sp1(a_sp1), .a_p1le(a_p1le),
        .a_p21(a_p21), .a_p1u1(a_p1u1), .state_dbg(state_dbg)
    );

    vpi_var_pattern_driver #(.NUM_VECS(1), .TIMEOUT_CYCLES(64)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .host_ack(ack1),
        .valid(valid1), .seq(seq1), .done(done1), .timeout_err(timeout_err1),
        .onebit(onebit1), .a_p1(a_p1_1), .a_sp1(a_sp1_1), .a_p1le(a_p1le_1),
        .a_p21(a_p21_1), .a_p1u1(a_p1u1_1), .state_dbg(state_dbg1)
    );

    // Observed word: {seq, onebit, a_p1, a_sp1, a_p1le(elem0 first), a_p21, a_p1u1}
    logic [24:0] act_w;
    assign act_w = {seq, onebit, a_p1, a_sp1, a_p1le, a_p21, a_p1u1};

    int n_cmp = 0;
    int n_bad = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: fields of vector k from the mapping rules, by arithmetic.
    function automatic logic [24:0] model(input int k);
        int lo;
        lo = k % 4;
        return {8'(k), 1'(k % 2), 2'(lo), 2'(3 - lo),
                2'((k % 2) * 2 + (k / 2) % 2),
                6'(lo * 16 + (3 - lo) * 4 + (k / 2) % 4),
                4'(k % 16)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic        prev_valid = 1'b0;
    logic [24:0] cur_exp = '0;

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_vector: got %0h, required none (t=%0t)", act_w, $time);
            end else begin
                cur_exp = exp_q.pop_front();
                check("vector", 32'(act_w), 32'(cur_exp));
            end
        end else if (valid && prev_valid) begin
            check("stable_while_valid", 32'(act_w), 32'(cur_exp));
        end
        prev_valid = valid;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        start = 1'b0; host_ack = 1'b0; start1 = 1'b0; ack1 = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input logic lvl, input string name);
        int t;
        t = 0;
        while (valid !== lvl && t < 200) begin
            cycles(1);
            t++;
        end
        if (valid !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: valid=%b, required %b within 200 cycles", name, valid, lvl);
        end
    endtask

    // Host reply to a vector already presented: ack after ack_dly cycles,
    // wait for valid to fall, drop ack after drop_dly more cycles.
    task automatic finish_vec(input int ack_dly, input int drop_dly);
        cycles(ack_dly);
        host_ack = 1'b1;
        wait_valid(1'b0, "valid_fall");
        cycles(drop_dly);
        host_ack = 1'b0;
    endtask

    task automatic host_vec(input int ack_dly, input int drop_dly);
        wait_valid(1'b1, "valid_rise");
        finish_vec(ack_dly, drop_dly);
    endtask

    task automatic check_done(input string name);
        cycles(1);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_valid"}, 32'(valid), 32'd0);
        check({name, "_err"}, 32'(timeout_err), 32'd0);
        check({name, "_last_vec"}, 32'({onebit, a_p1, a_sp1, a_p1le, a_p21, a_p1u1}),
              32'(model(7) & 25'h1FFFF));
        check({name, "_seq"}, 32'(seq), 32'd7);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_run(input string name, input int max_dly);
        do_reset();
        for (int k = 0; k < 8; k++) exp_q.push_back(model(k));
        pulse_start();
        for (int k = 0; k < 8; k++)
            host_vec($urandom_range(0, max_dly), $urandom_range(0, max_dly));
        check_done(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cycles(2);
        do_reset();

        // reset state
        check("reset_outputs", 32'(act_w), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(timeout_err), 32'd0);

        // directed run: ack 2 cycles after valid rise, dropped 1 cycle later
        for (int k = 0; k < 8; k++) exp_q.push_back(model(k));
        pulse_start();
        check("start_latency_valid", 32'(valid), 32'd1);
        check("start_latency_seq", 32'(seq), 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_valid(1'b1, "valid_rise");
            if (k == 5) begin
                check("k5_onebit", 32'(onebit), 32'd1);
                check("k5_a_p1", 32'(a_p1), 32'b01);
                check("k5_a_sp1_signed", 32'(int'(a_sp1)), 32'hFFFF_FFFE);
                check("k5_a_p1le_e0", 32'(a_p1le[0]), 32'd1);
                check("k5_a_p1le_e1", 32'(a_p1le[1]), 32'd0);
                check("k5_a_p21", 32'(a_p21), 32'b01_10_10);
                check("k5_a_p1u1", 32'(a_p1u1), 32'b0101);
            end
            finish_vec(2, 0);
        end
        check_done("directed");
        pulse_start();
        check("done_ignores_start_done", 32'(done), 32'd1);
        check("done_ignores_start_valid", 32'(valid), 32'd0);

        // ack held high from before start: vector 0 taken, then RELEASE times out
        do_reset();
        host_ack = 1'b1;
        cycles(1);
        check("ack_in_idle_valid", 32'(valid), 32'd0);
        exp_q.push_back(model(0));
        pulse_start();
        check("held_ack_valid_rise", 32'(valid), 32'd1);
        cycles(1);
        check("held_ack_accept", 32'(valid), 32'd0);
        cycles(63);
        check("release_tmo_early", 32'(timeout_err), 32'd0);
        cycles(1);
        check("release_tmo_err", 32'(timeout_err), 32'd1);
        check("release_tmo_seq", 32'(seq), 32'd0);
        check("release_tmo_valid", 32'(valid), 32'd0);
        host_ack = 1'b0;
        pulse_start();
        check("error_ignores_start_err", 32'(timeout_err), 32'd1);
        check("error_ignores_start_valid", 32'(valid), 32'd0);

        // ack never asserted: PRESENT times out 64 cycles after valid rose
        do_reset();
        exp_q.push_back(model(0));
        pulse_start();
        cycles(63);
        check("present_tmo_early", 32'(timeout_err), 32'd0);
        cycles(1);
        check("present_tmo_err", 32'(timeout_err), 32'd1);
        check("present_tmo_seq", 32'(seq), 32'd0);
        check("present_tmo_valid", 32'(valid), 32'd0);
        check("present_tmo_done", 32'(done), 32'd0);

        // async reset while in RELEASE at k=3, then a fresh full run
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(model(k));
        pulse_start();
        for (int k = 0; k < 3; k++)
            host_vec($urandom_range(0, 3), $urandom_range(0, 3));
        wait_valid(1'b1, "valid_rise");
        check("pre_abort_seq", 32'(seq), 32'd3);
        host_ack = 1'b1;
        wait_valid(1'b0, "valid_fall");
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'(act_w), 32'd0);
        check("abort_flags", 32'({valid, done, timeout_err}), 32'd0);
        rst = 1'b0;
        host_ack = 1'b0;
        cycles(2);
        check("abort_idle_valid", 32'(valid), 32'd0);
        exp_q.push_back(model(0));
        pulse_start();
        check("restart_valid", 32'(valid), 32'd1);
        check("restart_seq", 32'(seq), 32'd0);
        for (int k = 1; k < 8; k++) exp_q.push_back(model(k));
        for (int k = 0; k < 8; k++)
            host_vec($urandom_range(0, 3), $urandom_range(0, 3));
        check_done("after_abort");

        // single-vector instance
        do_reset();
        start1 = 1'b1;
        cycles(1);
        start1 = 1'b0;
        check("nv1_valid", 32'(valid1), 32'd1);
        check("nv1_vec", 32'({seq1, onebit1, a_p1_1, a_sp1_1, a_p1le_1, a_p21_1, a_p1u1_1}),
              32'(model(0)));
        ack1 = 1'b1;
        begin
            int t;
            t = 0;
            while (valid1 !== 1'b0 && t < 200) begin
                cycles(1);
                t++;
            end
            check("nv1_valid_fall", 32'(valid1), 32'd0);
        end
        ack1 = 1'b0;
        cycles(1);
        check("nv1_done", 32'(done1), 32'd1);
        check("nv1_seq", 32'(seq1), 32'd0);
        start1 = 1'b1;
        cycles(1);
        start1 = 1'b0;
        cycles(1);
        check("nv1_restart_done", 32'(done1), 32'd1);
        check("nv1_restart_valid", 32'(valid1), 32'd0);

        // ack toggled on every PRESENT cycle: no skipped or repeated indices
        random_run("fast_toggle", 0);

        // randomized host timing
        for (int r = 0; r < 3; r++) random_run("random", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vpi_var_pattern_driver.md
Name: vpi_var_pattern_driver

Overview:
- Verilog-side producer for VPI variable-model regression tests.
- Drives a deterministic sequence of vectors onto public logic variables of varied shapes: one-bit, packed, signed packed, little-endian packed, multi-dim packed, and packed-over-unpacked.
- A host (C via VPI, or a bench) reads each vector and acknowledges it through a 4-phase valid/ack handshake.
- This is the writer end of the public-variable path: the host reads, and this block produces and sequences.

Parameters:
- NUM_VECS, 8, number of vectors in one run (range 1..256).
- TIMEOUT_CYCLES, 64, maximum cycles to wait in any handshake phase before error (must be ≥1).

Ports:
- clk  input  1  sole clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle pulse; begins a run from IDLE. Ignored in other states.
- host_ack  input  1  host acknowledge. The VPI side writes it at posedge clk.
- valid  output  1  current vector is stable and readable.
- seq  output  8  index k of the presented vector.
- done  output  1  sticky; all NUM_VECS vectors acknowledged.
- timeout_err  output  1  sticky; a handshake phase exceeded TIMEOUT_CYCLES.
- onebit  output  1  k[0].
- a_p1  output  2  k[1:0].
- a_sp1  output  2  signed, ~k[1:0].
- a_p1le  output  2  little-endian [0:1]; element 0 = k[0], element 1 = k[1].
- a_p21  output  6  packed [2:0][1:0]: [2]=k[1:0], [1]=~k[1:0], [0]=k[2:1].
- a_p1u1  output  4  flattened unpacked [1:0] of [1:0]: elem1=k[3:2], elem0=k[1:0] (bits [3:2]=elem1).

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - seq, valid, done, timeout_err and all data outputs go to 0.
  - Timeout counter goes to 0.
- States: IDLE, PRESENT, RELEASE, DONE, ERROR.
- IDLE:
  - Outputs hold 0.
  - start=1 → PRESENT with k=0. Data outputs are loaded for k=0 and valid=1 on the same edge (latency 1 cycle from start).
- PRESENT:
  - valid=1; data and seq are stable for the whole phase.
  - host_ack=1 sampled → RELEASE, valid=0 on that edge. Data outputs hold their values.
- RELEASE:
  - Waits for host_ack=0.
  - On host_ack=0 with k<NUM_VECS-1: k increments, the new vector loads, valid=1, → PRESENT. This happens on one edge; there is no bubble beyond the ack-low cycle.
  - On host_ack=0 with k=NUM_VECS-1: → DONE, done=1, valid=0. Data outputs keep the last vector.
- DONE:
  - Terminal until rst. start is ignored.
- Timeout:
  - The counter clears on every state transition.
  - In PRESENT or RELEASE it increments each cycle the awaited condition is false.
  - When the count reaches TIMEOUT_CYCLES: → ERROR, timeout_err=1, valid=0. seq holds the failing index.
- ERROR:
  - Terminal until rst. start is ignored.
- host_ack=1 while in IDLE/DONE/ERROR: no effect.
- host_ack already 1 when PRESENT is entered: accepted on the first PRESENT cycle.
- host_ack never pulses within one cycle: both edges must be seen.
- Data mapping:
  - Bits are computed from the 8-bit k. Index k bits ≥ width are 0; for NUM_VECS ≤ 4, k[3:2]=0.
  - a_sp1 is declared signed; for k=0 it reads -1 (2'b11).
- NUM_VECS=1: a single PRESENT/RELEASE pair, then DONE.
- rst asserted mid-handshake: outputs clear immediately and asynchronously. A fresh start is required.

Test Plan:
- Reset then start, with ack answered 2 cycles after each valid rise and dropped 1 cycle later → 8 vectors.
  - At k=5: onebit=1, a_p1=01, a_sp1=10 (-2), a_p1le elem0=1 elem1=0, a_p21=6'b01_10_10, a_p1u1=4'b0101.
  - done=1 after the 8th ack drops; timeout_err=0.
- host_ack held 1 continuously after start → vector 0 accepted, then RELEASE waits.
  - After 64 cycles: timeout_err=1, seq=0, valid=0.
- host_ack never asserted → timeout_err=1 exactly 64 cycles after valid rose; seq=0.
- Assert rst while in RELEASE at k=3 → all outputs 0 immediately. Then start → seq=0, valid=1 one cycle later.
- NUM_VECS=1 with one handshake → done=1, seq=0. A second start pulse leaves done=1 and valid=0.
- Ack toggled on every PRESENT cycle → exactly one seq increment per full 4-phase cycle; no skipped or repeated indices.
